// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the riscv32 execute stage.
// Single-cycle ops finish one cycle after accept; MUL/DIVU/REMU iterate one
// bit per cycle for WIDTH cycles. Operands and results use valid/ready.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(9);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(10);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(11);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(12);
    localparam logic [OPW-1:0] OP_REMU = OPW'(13);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state, state_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0] a_r, a_n, b_r, b_n, acc_r, acc_n, out_n;
    logic [OPW-1:0]   op_r, op_n;
    logic             accept, is_iter;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_res, mul_sum, step_a, step_b, step_acc, step_res;
    logic [WIDTH:0]   rem_sh, trial;

    assign shamt = y[SHW-1:0];

    // Result of every op that completes in one cycle, including divide by zero
    always_comb begin
        single_res = '0;
        case (op)
            OP_ADD:  single_res = x + y;
            OP_SUB:  single_res = x - y;
            OP_AND:  single_res = x & y;
            OP_OR:   single_res = x | y;
            OP_XOR:  single_res = x ^ y;
            OP_SLL:  single_res = x << shamt;
            OP_SRL:  single_res = x >> shamt;
            OP_SRA:  single_res = $signed(x) >>> shamt;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, x < y};
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = x;
            default: single_res = '0;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide.
    // MUL: a_r = multiplicand, b_r = multiplier, acc_r = partial product.
    // DIV: a_r = dividend shifting out / quotient shifting in, b_r = divisor,
    //      acc_r = partial remainder.
    always_comb begin
        mul_sum = acc_r + (b_r[0] ? a_r : '0);
        rem_sh  = {acc_r, a_r[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_r};
        if (op_r == OP_MUL) begin
            step_acc = mul_sum;
            step_a   = a_r << 1;
            step_b   = b_r >> 1;
        end else begin
            step_b = b_r;
            if (!trial[WIDTH]) begin
                step_acc = trial[WIDTH-1:0];
                step_a   = {a_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_a   = {a_r[WIDTH-2:0], 1'b0};
            end
        end
        step_res = (op_r == OP_DIVU) ? step_a : step_acc;
    end

    assign is_iter = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (y != '0));

    // Next state, handshake outputs and next datapath values
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        a_n       = a_r;
        b_n       = b_r;
        acc_n     = acc_r;
        op_n      = op_r;
        out_n     = out;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                busy  = 1'b1;
                a_n   = step_a;
                b_n   = step_b;
                acc_n = step_acc;
                cnt_n = cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    state_n = DONE;
                    out_n   = step_res;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_n = IDLE;
                    out_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // A new accept overrides the consume-to-IDLE path out of DONE
        accept = in_valid && in_ready;
        if (accept) begin
            op_n  = op;
            a_n   = x;
            b_n   = y;
            acc_n = '0;
            if (is_iter) begin
                state_n = BUSY;
                cnt_n   = CNTW'(WIDTH);
                out_n   = '0;
            end else begin
                state_n = DONE;
                cnt_n   = '0;
                out_n   = single_res;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Datapath registers; reset discards any partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
            op_r  <= '0;
            out   <= '0;
        end else begin
            cnt   <= cnt_n;
            a_r   <= a_n;
            b_r   <= b_n;
            acc_r <= acc_n;
            op_r  <= op_n;
            out   <= out_n;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a stimulus process pushes expected results,
// a monitor process pops and compares whenever a result is presented.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]   op;
    logic [W-1:0] x, y, out;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] exp;
        int           acc;
        int           lat;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the op table
    function automatic logic [W-1:0] model(input int unsigned o, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned sh;
        logic [W-1:0] r;
        sh = b % W;
        case (o)
            1:  r = a + b;
            2:  r = a - b;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = a << sh;
            7:  r = a >> sh;
            8:  r = $signed(a) >>> sh;
            9:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            10: r = (a < b) ? W'(1) : W'(0);
            11: r = a * b;
            12: r = (b == 0) ? '1 : a / b;
            13: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Monitor: drives out_ready, checks protocol rules and scoreboard results
    initial begin
        bit seen;
        int run;
        item_t it;
        seen = 0;
        run = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (reset) begin
                seen = 0;
                run = 0;
            end else begin
                if (busy) run++;
                else if (run != 0) begin
                    chk("busy_len", W'(run), W'(W));
                    run = 0;
                end
                chk("in_ready_rule", W'(in_ready), out_valid ? W'(out_ready) : W'(!busy));
                if (!out_valid) begin
                    chk("out_zero_when_invalid", out, '0);
                end else if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got out=%h expected no result (cycle %0d)", out, cyc);
                end else begin
                    it = sb[0];
                    if (!seen) begin
                        chk("latency", W'(cyc - it.acc), W'(it.lat));
                        seen = 1;
                    end
                    chk("result", out, it.exp);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, output int acc, output bit first);
        int tries;
        bit ok;
        item_t it;
        tries = 0;
        ok = 0;
        acc = -1;
        @(negedge clk);
        op = o;
        x = a;
        y = b;
        in_valid = 1'b1;
        while (!ok) begin
            #1;
            if (in_ready) begin
                it.exp = e;
                it.acc = cyc;
                it.lat = ((o == 11) || (((o == 12) || (o == 13)) && (b != 0))) ? W + 1 : 1;
                sb.push_back(it);
                acc = cyc;
                ok = 1;
            end else begin
                tries++;
                if (tries > 200) begin
                    total++;
                    bad++;
                    $display("FAIL issue_timeout: op %0d not accepted after %0d cycles, required acceptance", o, tries);
                    break;
                end
                @(negedge clk);
            end
        end
        first = (tries == 0);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the op in flight must not notice
        in_valid = 1'b0;
        op = 4'($urandom);
        x = $urandom;
        y = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int acc, acc_prev;
        bit first;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        in_valid = 1'b0;
        op = '0;
        x = '0;
        y = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_out", out, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        issue(4'd1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, acc, first);
        issue(4'd2, 32'd0, 32'd1, 32'hFFFF_FFFF, acc, first);

        // Back-to-back stream: one accept per cycle
        issue(4'd6, 32'd1, 32'd31, 32'h8000_0000, acc_prev, first);
        issue(4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, acc, first);
        chk("stream_ready", W'(first), W'(1));
        chk("stream_gap", W'(acc - acc_prev), W'(1));
        acc_prev = acc;
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, acc, first);
        chk("stream_ready", W'(first), W'(1));
        chk("stream_gap", W'(acc - acc_prev), W'(1));
        acc_prev = acc;
        issue(4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, acc, first);
        chk("stream_ready", W'(first), W'(1));
        chk("stream_gap", W'(acc - acc_prev), W'(1));

        issue(4'd11, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, acc, first);
        issue(4'd12, 32'd100, 32'd7, 32'd14, acc, first);
        issue(4'd13, 32'd100, 32'd7, 32'd2, acc, first);
        issue(4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, acc, first);
        issue(4'd13, 32'd5, 32'd0, 32'd5, acc, first);
        drain();

        // Backpressure: AND held, then XOR accepted in the consume cycle
        rdy_mode = 2;
        issue(4'd3, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, acc, first);
        repeat (5) @(negedge clk);
        #2;
        rdy_mode = 0;
        issue(4'd5, 32'hAAAA_5555, 32'h0F0F_F0F0, 32'hA5A5_A5A5, acc, first);
        chk("bp_same_cycle_accept", W'(first), W'(1));
        drain();

        // Reset in the middle of a DIVU
        issue(4'd12, 32'hDEAD_BEEF, 32'd3, 32'h0, acc, first);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", W'(out_valid), '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_out", out, '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(4'd1, 32'd2, 32'd3, 32'd5, acc, first);
        drain();

        // Randomised traffic with random backpressure and gaps
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 40));
                2: ra = W'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(ro, ra, rb, model(ro, ra, rb), acc, first);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rdy_mode = 0;
        drain();

        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised ALU for the riscv32 execute stage.
- Keeps the existing op encodings 0=ZERO, 1=ADD, 2=SUBTRACT and adds logic, shift and compare ops, plus iterative MUL, DIVU and REMU.
- Operands and results move over valid/ready handshakes, so the pipeline can stall on long ops.
- All results are registered; iterative ops take WIDTH cycles each.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two.
OPW, 4, op-code width in bits.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  op/x/y valid
in_ready  output  1  block can accept a new operation this cycle
op  input  OPW  operation code
x  input  WIDTH  operand A
y  input  WIDTH  operand B
out_valid  output  1  out holds a completed result
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  result
busy  output  1  iterative op in progress (state BUSY)

Behaviour:
- Op codes:
  - 0 ZERO -> 0; 1 ADD -> x+y; 2 SUB -> x-y; 3 AND; 4 OR; 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA: shift x by y[log2(WIDTH)-1:0].
  - 9 SLT (signed) -> 1/0; 10 SLTU -> 1/0.
  - 11 MUL -> low WIDTH bits of x*y (unsigned and signed give the same low half).
  - 12 DIVU -> x/y; 13 REMU -> x%y.
  - 14-15 -> 0, handled as single-cycle ops.
- Add/sub wrap modulo 2^WIDTH; there is no carry or overflow output.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating; in_ready=0, busy=1.
  - DONE: out_valid=1, out stable.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Single-cycle ops (0-10, 14, 15): accepted in cycle N; IDLE->DONE; out_valid=1 from cycle N+1.
- MUL/DIVU/REMU:
  - Accepted in cycle N; IDLE->BUSY with an iteration counter loaded to WIDTH.
  - Each BUSY cycle performs one shift-add step (MUL) or one restoring-subtract step (DIV/REM) and decrements the counter.
  - When the counter reaches 0: BUSY->DONE; out_valid=1 from cycle N+WIDTH+1.
- Divide by zero (y==0) is detected at accept and skips BUSY (single-cycle latency):
  - DIVU -> all ones.
  - REMU -> x.
- DONE:
  - Holds out and out_valid until out_ready.
  - in_ready = out_ready in DONE, so a new op can be accepted in the same cycle the result is consumed (back-to-back throughput of 1/cycle for single-cycle ops).
  - On consume with no new accept: DONE->IDLE, out_valid=0 next cycle.
  - On consume with a new accept: go to DONE or BUSY according to the new op.
- x, y and op are captured at accept; later input changes have no effect on the op in flight.
- in_valid while BUSY is ignored (in_ready=0); the producer must hold it.
- Reset (asynchronous, any state, including mid-iteration):
  - state=IDLE; out=0, out_valid=0, busy=0, in_ready=1 after reset deasserts.
  - Counter and work registers cleared; the partial result is discarded.
- out is 0 whenever out_valid=0 (registered clear on consume/reset).

Test Plan:
- Reset then ADD x=0xFFFF_FFFF, y=1, out_ready=1 -> out_valid one cycle after accept, out=0x0000_0000; then SUB x=0, y=1 -> 0xFFFF_FFFF.
- Back-to-back with out_ready=1:
  - Stream SLL x=1, y=31 -> 0x8000_0000.
  - SRA x=0x8000_0000, y=4 -> 0xF800_0000.
  - SLT x=0xFFFF_FFFF, y=1 -> 1.
  - SLTU same operands -> 0.
  - Requires one result per cycle, in_ready never low.
- MUL x=0x0001_0000, y=0x0001_0001 (WIDTH=32) -> busy for 32 cycles, in_ready=0 throughout, out_valid at accept+33, out=0x0001_0000.
- DIVU x=100, y=7 -> out=14 at accept+33; REMU same -> 2; DIVU x=5, y=0 -> 0xFFFF_FFFF at accept+1; REMU x=5, y=0 -> 5 at accept+1.
- Backpressure: AND result held with out_ready=0 for 5 cycles -> out and out_valid stable, in_ready=0; on out_ready=1 with in_valid=1 (XOR) -> new op accepted that same cycle, XOR result next cycle.
- Assert reset at BUSY cycle 10 of a DIVU -> out_valid=0, busy=0, out=0 immediately; after release, ADD 2+3 -> 5 at accept+1 with no stale-result leakage.
